// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue FSM driving the alu_top start/done handshake, with per-command timeout.
// Optional macro ALU_SEQ_DIV0_GUARD_EN answers div-by-zero locally without starting the ALU.
module alu_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_result,
  output logic [1:0]                   rsp_op,
  output logic                         rsp_err,
  output logic                         alu_start,
  output logic [1:0]                   alu_op_code,
  output logic [7:0]                   alu_operand_A,
  output logic [7:0]                   alu_operand_B,
  input  logic [15:0]                  alu_result,
  input  logic                         alu_done,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [17:0]      mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full, empty, push, pop;
  logic [17:0]      head;
  logic             head_div0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_prev_q;
  logic             done_edge, timeout_hit;
  logic [1:0]       op_q;
  logic [7:0]       a_q, b_q;
  logic [15:0]      result_q;
  logic             err_q;

  assign full      = (count_q == (PTR_W+1)'(CMD_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem[rd_ptr_q];

`ifdef ALU_SEQ_DIV0_GUARD_EN
  assign head_div0 = (head[17:16] == 2'b11) && (head[7:0] == 8'h00);
`else
  assign head_div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Rising-edge detect works for pulse and level done; a level left high is masked by ISSUE.
  assign done_edge   = alu_done && !done_prev_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = head_div0 ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_edge || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= (state_q == ISSUE) ? 1'b1 : alu_done;
      if (pop) begin
        op_q  <= head[17:16];
        a_q   <= head[15:8];
        b_q   <= head[7:0];
        cnt_q <= '0;
        if (head_div0) begin
          result_q <= 16'hFFFF;
          err_q    <= 1'b1;
        end
      end else if (state_q == WAIT) begin
        if (done_edge) begin
          result_q <= alu_result;
          err_q    <= 1'b0;
        end else if (timeout_hit) begin
          result_q <= 16'h0000;
          err_q    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign alu_start     = (state_q == ISSUE);
  assign alu_op_code   = op_q;
  assign alu_operand_A = a_q;
  assign alu_operand_B = b_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = result_q;
  assign rsp_op        = op_q;
  assign rsp_err       = err_q;
  assign busy          = (state_q != IDLE);
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed, table-driven bench for alu_cmd_sequencer with a behavioural ALU responder.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_err;
  logic        alu_start;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_operand_A, alu_operand_B;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .alu_start(alu_start), .alu_op_code(alu_op_code),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_result(alu_result),
    .alu_done(alu_done), .busy(busy), .fifo_count(fifo_count)
  );

  // ALU responder: NORMAL answers after a latency, DEAD never answers, MANUAL is bench-driven.
  localparam int M_NORMAL = 0;
  localparam int M_DEAD   = 1;
  localparam int M_MANUAL = 2;
  int          mode = M_NORMAL;
  logic        man_done = 1'b0;
  logic [15:0] man_result = '0;
  logic        model_done = 1'b0;
  logic [15:0] model_result = '0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  int          starts = 0;

  assign alu_done   = (mode == M_MANUAL) ? man_done : model_done;
  assign alu_result = (mode == M_MANUAL) ? man_result : model_result;

  function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] s;
    case (op)
      2'b00: begin s = a + b; return {8'h00, s}; end
      2'b01: begin s = a - b; return {8'h00, s}; end
      2'b10: return 16'(a) * 16'(b);
      default: return (b == 8'h00) ? {a, 8'hFF} : {a % b, a / b};
    endcase
  endfunction

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (mode == M_NORMAL) begin
      if (alu_start) begin
        m_busy <= 1'b1;
        m_cnt  <= 2;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          model_done   <= 1'b1;
          model_result <= alu_f(alu_op_code, alu_operand_A, alu_operand_B);
          m_busy       <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else begin
      m_busy <= 1'b0;
    end
    if (alu_start) starts <= starts + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [15:0] res, input logic [1:0] op,
                         input logic err);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_result"}, 32'(rsp_result), 32'(res));
      chk({name, "_op"}, 32'(rsp_op), 32'(op));
      chk({name, "_err"}, 32'(rsp_err), 32'(err));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!alu_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!alu_start) chk({name, "_no_start"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec_t;

  vec_t seq_v[5];
  vec_t burst_v[5];

  initial begin
    int s0, k;
    logic [15:0] held;
    bit stable;

    seq_v[0] = '{2'b00, 8'd33, 8'd25, 16'h003A};
    seq_v[1] = '{2'b01, 8'd30, 8'd10, 16'h0014};
    seq_v[2] = '{2'b10, 8'd69, 8'd6, 16'h019E};
    seq_v[3] = '{2'b11, 8'd243, 8'd22, 16'h010B};
    seq_v[4] = '{2'b11, 8'd7, 8'd9, 16'h0700};
    burst_v[0] = '{2'b00, 8'd200, 8'd100, 16'h002C};
    burst_v[1] = '{2'b01, 8'd5, 8'd9, 16'h00FC};
    burst_v[2] = '{2'b10, 8'd255, 8'd255, 16'hFE01};
    burst_v[3] = '{2'b11, 8'd100, 8'd7, 16'h020E};
    burst_v[4] = '{2'b00, 8'd1, 8'd2, 16'h0003};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Sequential ops, one at a time
    for (int i = 0; i < 5; i++) begin
      s0 = starts;
      push(seq_v[i].op, seq_v[i].a, seq_v[i].b);
      get_rsp($sformatf("seq%0d", i), seq_v[i].res, seq_v[i].op, 1'b0);
      repeat (2) @(negedge clk);
      chk($sformatf("seq%0d_starts", i), 32'(starts - s0), 32'd1);
    end

    // Burst with response stalled: one command in the FSM, four queued
    for (int i = 0; i < 5; i++) push(burst_v[i].op, burst_v[i].a, burst_v[i].b);
    chk("burst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("burst_fifo_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++)
      get_rsp($sformatf("burst%0d", i), burst_v[i].res, burst_v[i].op, 1'b0);
    repeat (2) @(negedge clk);
    chk("burst_drained", 32'(fifo_count), 32'd0);

    // Backpressure in RESP with another command waiting
    push(2'b00, 8'd10, 8'd20);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    push(2'b01, 8'd50, 8'd8);
    s0 = starts;
    held = rsp_result;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== held || alu_start) stable = 1'b0;
    end
    chk("bp_held_result", 32'(held), 32'h001E);
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_no_start", 32'(starts - s0), 32'd0);
    get_rsp("bp0", 16'h001E, 2'b00, 1'b0);
    get_rsp("bp1", 16'h002A, 2'b01, 1'b0);

    // Timeout: 64 WAIT cycles, late done ignored
    mode = M_DEAD;
    push(2'b00, 8'd1, 8'd1);
    wait_start("to");
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", 32'(k), 32'd65);
    mode = M_MANUAL;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("to_late_done_valid", 32'(rsp_valid), 32'd1);
    get_rsp("to", 16'h0000, 2'b00, 1'b1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_idle_rsp", 32'(rsp_valid), 32'd0);

    // Level-held done carried into the next command
    push(2'b00, 8'd5, 8'd7);
    wait_start("lvl0");
    repeat (2) @(negedge clk);
    man_result = 16'h000C;
    man_done = 1'b1;
    get_rsp("lvl0", 16'h000C, 2'b00, 1'b0);
    man_result = 16'hBEEF;
    push(2'b01, 8'd9, 8'd4);
    wait_start("lvl1");
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) stable = 1'b0;
    end
    chk("lvl_no_stale_capture", 32'(stable), 32'd1);
    man_done = 1'b0;
    @(negedge clk);
    man_result = 16'h0005;
    man_done = 1'b1;
    get_rsp("lvl1", 16'h0005, 2'b01, 1'b0);
    man_done = 1'b0;
    @(negedge clk);

    // Asynchronous reset during WAIT with a queued command behind it
    mode = M_DEAD;
    push(2'b10, 8'd12, 8'd13);
    push(2'b00, 8'd3, 8'd4);
    wait_start("rst");
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_alu_bus", {14'd0, alu_op_code, alu_operand_A, alu_operand_B}, 32'd0);
    chk("arst_rsp", {15'd0, rsp_valid, rsp_result}, 32'd0);
    chk("arst_rsp_err_op", {29'd0, rsp_err, rsp_op}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mode = M_NORMAL;
    s0 = starts;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stable = 1'b0;
    end
    chk("arst_no_response", 32'(stable), 32'd1);
    chk("arst_no_start", 32'(starts - s0), 32'd0);

    // Divide by zero
    s0 = starts;
    push(2'b11, 8'd50, 8'd0);
`ifdef ALU_SEQ_DIV0_GUARD_EN
    get_rsp("div0", 16'hFFFF, 2'b11, 1'b1);
    repeat (2) @(negedge clk);
    chk("div0_no_start", 32'(starts - s0), 32'd0);
`else
    get_rsp("div0", 16'h32FF, 2'b11, 1'b0);
    repeat (2) @(negedge clk);
    chk("div0_start", 32'(starts - s0), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator that drives the start/op_code/operand/done handshake of alu_top.
- Buffers ALU commands from a host in a small FIFO and issues them one at a time.
- Holds operands and op_code stable until alu_done, captures the 16-bit result, and returns it over a valid/ready response channel.
- Adds a per-command timeout so a stalled ALU cannot hang the host.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of two, minimum 2
TIMEOUT, 64, cycles allowed in WAIT before abort; minimum 2
CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  8  operand A
cmd_b  in  8  operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_result  out  16  ALU result; for div: {remainder, quotient}
rsp_op  out  2  op_code of the completed command
rsp_err  out  1  1 = timeout or guarded command, result invalid
alu_start  out  1  one-cycle start pulse to the ALU
alu_op_code  out  2  to ALU op_code
alu_operand_A  out  8  to ALU operand_A
alu_operand_B  out  8  to ALU operand_B
alu_result  in  16  from ALU
alu_done  in  1  from ALU (pulse or level)
busy  out  1  FSM not in IDLE
fifo_count  out  log2(CMD_DEPTH)+1  commands queued

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs go to 0, except cmd_ready, which is 1.
  - Reset mid-command aborts the command with no response; the ALU is not notified.
- FIFO:
  - A push occurs when cmd_valid&&cmd_ready; cmd_ready = !full.
  - A pop occurs only in IDLE.
  - Simultaneous push and pop is allowed at any level except full, where cmd_ready is already 0 (no bypass).
  - Pointers wrap modulo CMD_DEPTH.
  - fifo_count is registered and updates the cycle after a push or pop.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop the head into the alu_op_code/alu_operand_A/alu_operand_B registers, clear the timeout counter, and go to ISSUE.
  - ISSUE: alu_start=1 for exactly this one cycle; go to WAIT.
  - WAIT: done is detected on the alu_done rising edge (alu_done=1 with the previous-cycle sample 0), which works for both pulse and level done. The previous-cycle sample register is forced to 1 during ISSUE, so a stale high level is ignored.
    - On done: capture alu_result into rsp_result, set rsp_err=0, go to RESP.
    - Otherwise, if the counter reaches TIMEOUT-1: rsp_result=16'h0000, rsp_err=1, go to RESP.
    - Otherwise: increment the counter.
  - RESP: rsp_valid=1. rsp_result, rsp_op and rsp_err stay stable until rsp_ready=1; in that cycle the handshake completes and the FSM goes to IDLE.
- alu_op_code and ALU operands stay constant from ISSUE through the end of RESP; the ALU add/sub path and result mux are combinational on these inputs.
- Latency: with an empty FIFO, rsp_valid rises 4 + (cycles from alu_start to alu_done edge) cycles after the command is accepted. Every command takes at least one idle cycle between commands.
- rsp_result width rule: add/sub results are zero-extended by the ALU. The sequencer passes the 16-bit result through unmodified and does no arithmetic.
- alu_done edges seen outside WAIT are ignored, including a late done after a timeout.

Optional Feature:
Macro ALU_SEQ_DIV0_GUARD_EN.
- Defined: a popped command with op=11 and B=8'h00 skips ISSUE and WAIT.
  - No alu_start is issued.
  - The FSM goes IDLE -> RESP with rsp_result=16'hFFFF and rsp_err=1.
- Undefined: divide-by-zero is issued to the ALU like any other command. rsp_result is whatever the ALU returns, or a timeout.

Test Plan:
1. Sequential ops: add 33,25 / sub 30,10 / mul 69,6 / div 243,22 each in turn, rsp_ready=1 → responses 16'h003A, 16'h0014, 16'h019E, 16'h010B in order, rsp_err=0, and exactly one alu_start pulse per command.
2. Burst push of 5 commands with the FSM stalled (rsp_ready=0) → cmd_ready drops once 4 are queued and fifo_count reads 4. Responses drain in FIFO order once rsp_ready=1. add 200,100 → 16'h002C (wrap).
3. Backpressure: hold rsp_ready=0 for 10 cycles during RESP → rsp_valid and rsp_result stay stable, and no new alu_start is issued until the handshake completes.
4. Timeout: tie alu_done=0, issue add 1,1 → rsp_valid with rsp_err=1 and rsp_result=0 after 64 WAIT cycles. A later alu_done pulse is ignored.
5. Level-held done: alu_done held high from the previous command into the next ISSUE → no capture until a 0→1 edge occurs.
6. Reset during WAIT of a mul → all outputs 0, cmd_ready=1, FIFO empty, no response. With ALU_SEQ_DIV0_GUARD_EN defined: div 50,0 → 16'hFFFF, rsp_err=1, no alu_start.
